// File: rtl/song_sequencer_if.sv
// Song ROM read bus and note-player load bus for song_sequencer.
// The sequencer is the master: it drives the ROM address and the voice load
// strobes and fields, and receives synchronous ROM data.
interface song_sequencer_if #(
    parameter int NUM_SONGS = 4,
    parameter int ADDR_W    = 5,
    parameter int VOICES    = 3,
    parameter int NOTE_W    = 6,
    parameter int DUR_W     = 6,
    parameter int META_W    = 3
);
    localparam int S_W = $clog2(NUM_SONGS);
    localparam int E_W = 1 + NOTE_W + DUR_W + META_W;

    logic [S_W+ADDR_W-1:0] rom_addr;
    logic [E_W-1:0]        rom_dout;
    logic [VOICES-1:0]     note_load;
    logic [NOTE_W-1:0]     note_out;
    logic [DUR_W-1:0]      note_dur;
    logic [META_W-1:0]     note_meta;

    modport master (
        output rom_addr, note_load, note_out, note_dur, note_meta,
        input  rom_dout
    );

    modport slave (
        input  rom_addr, note_load, note_out, note_dur, note_meta,
        output rom_dout
    );
endinterface

// File: rtl/song_sequencer.sv
// Song playback engine: walks a synchronous multi-song ROM, dispatches note
// entries round-robin to the voice bank and waits out advance entries in beats.
// restart / next_song rewind from any state; a zero-length advance, or a note
// in the last entry slot, ends the song (loop or stop).
module song_sequencer #(
    parameter int NUM_SONGS = 4,
    parameter int ADDR_W    = 5,
    parameter int VOICES    = 3,
    parameter int NOTE_W    = 6,
    parameter int DUR_W     = 6,
    parameter int META_W    = 3,
    localparam int S_W      = $clog2(NUM_SONGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             play,
    input  logic             restart,
    input  logic             next_song,
    input  logic             loop_en,
    input  logic             beat,
    song_sequencer_if.master bus,
    output logic [S_W-1:0]   song_idx,
    output logic             song_done,
    output logic             busy
);
    localparam int E_W  = 1 + NOTE_W + DUR_W + META_W;
    localparam int VP_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT, DONE} state_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] entry_q, entry_n;
    logic [S_W-1:0]    song_q, song_n;
    logic [VP_W-1:0]   voice_ptr_q, voice_ptr_n;
    logic [DUR_W-1:0]  beat_cnt_q, beat_cnt_n;
    logic [VOICES-1:0] load_q, load_n;
    logic [NOTE_W-1:0] note_q, note_n;
    logic [DUR_W-1:0]  dur_q, dur_n;
    logic [META_W-1:0] meta_q, meta_n;
    logic              done_q, done_n;
    logic              busy_q, busy_n;
    logic              end_song;

    // ROM entry fields, layout {adv, note, dur, meta}
    logic              ent_adv;
    logic [NOTE_W-1:0] ent_note;
    logic [DUR_W-1:0]  ent_dur;
    logic [META_W-1:0] ent_meta;

    assign ent_adv  = bus.rom_dout[E_W-1];
    assign ent_note = bus.rom_dout[E_W-2 -: NOTE_W];
    assign ent_dur  = bus.rom_dout[META_W +: DUR_W];
    assign ent_meta = bus.rom_dout[META_W-1:0];

    // Next-state and datapath updates; control pulses outrank the FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n     = state_q;
        entry_n     = entry_q;
        song_n      = song_q;
        voice_ptr_n = voice_ptr_q;
        beat_cnt_n  = beat_cnt_q;
        load_n      = '0;
        note_n      = note_q;
        dur_n       = dur_q;
        meta_n      = meta_q;
        done_n      = 1'b0;
        end_song    = 1'b0;

        case (state_q)
            IDLE: begin
                entry_n = '0;
                if (play) state_n = FETCH;
            end
            FETCH: begin
                if (play) state_n = DECODE;
            end
            DECODE: begin
                if (!ent_adv) begin
                    note_n      = ent_note;
                    dur_n       = ent_dur;
                    meta_n      = ent_meta;
                    load_n      = VOICES'(1) << voice_ptr_q;
                    voice_ptr_n = (voice_ptr_q == VP_W'(VOICES - 1)) ? '0 : voice_ptr_q + 1'b1;
                    if (entry_q == '1) begin
                        end_song = 1'b1;
                    end else begin
                        entry_n = entry_q + 1'b1;
                        state_n = FETCH;
                    end
                end else if (ent_dur != '0) begin
                    beat_cnt_n  = ent_dur;
                    voice_ptr_n = '0;
                    state_n     = WAIT;
                end else begin
                    end_song = 1'b1;
                end
            end
            WAIT: begin
                if (beat && play) begin
                    beat_cnt_n = beat_cnt_q - 1'b1;
                    if (beat_cnt_q == DUR_W'(1)) begin
                        // An advance in the last slot cannot wrap into entry 0.
                        if (entry_q == '1) begin
                            end_song = 1'b1;
                        end else begin
                            entry_n = entry_q + 1'b1;
                            state_n = FETCH;
                        end
                    end
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (end_song) begin
            done_n      = 1'b1;
            entry_n     = '0;
            voice_ptr_n = '0;
            state_n     = loop_en ? FETCH : DONE;
        end

        if (restart || next_song) begin
            entry_n     = '0;
            voice_ptr_n = '0;
            beat_cnt_n  = '0;
            load_n      = '0;
            done_n      = 1'b0;
            state_n     = play ? FETCH : IDLE;
            if (next_song) song_n = song_q + 1'b1;
        end

        busy_n = (state_n == FETCH) || (state_n == DECODE) || (state_n == WAIT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            entry_q     <= '0;
            song_q      <= '0;
            voice_ptr_q <= '0;
            beat_cnt_q  <= '0;
            load_q      <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            meta_q      <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_n;
            entry_q     <= entry_n;
            song_q      <= song_n;
            voice_ptr_q <= voice_ptr_n;
            beat_cnt_q  <= beat_cnt_n;
            load_q      <= load_n;
            note_q      <= note_n;
            dur_q       <= dur_n;
            meta_q      <= meta_n;
            done_q      <= done_n;
            busy_q      <= busy_n;
        end
    end

    assign bus.rom_addr  = {song_q, entry_q};
    assign bus.note_load = load_q;
    assign bus.note_out  = note_q;
    assign bus.note_dur  = dur_q;
    assign bus.note_meta = meta_q;
    assign song_idx      = song_q;
    assign song_done     = done_q;
    assign busy          = busy_q;
endmodule
